multi_flag_counter: RTL and testbench

- Parametrised, multi-channel successor of the plain binary trigger counter with threshold flag.
- Each channel counts its own trigger pulses against a shared threshold, with a selectable wrap, saturate or auto-reload mode.
- A winner register records the first channel to reach threshold, so the game controller can detect which player or lane finished first.

---
 rtl/multi_flag_counter.sv | 118 +++++++++++
 tb/tb_multi_flag_counter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_flag_counter.sv
// Multi-channel trigger counters with wrap/sat/reload modes, per-channel threshold flags and a first-to-threshold winner latch.
// Latency: count/flag/flag_pulse update on the same edge; winner follows flag_pulse by one cycle; no backpressure.
module multi_flag_counter #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 4,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       trigger,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [CNT_W-1:0]        threshold,
  input  logic [1:0]              mode,
  input  logic                    winner_clr,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       flag,
  output logic [NUM_CH-1:0]       flag_pulse,
  output logic                    any_flag,
  output logic                    winner_valid,
  output logic [ID_W-1:0]         winner_id
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_RELOAD = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  mode_e                    mode_eff;
  logic [NUM_CH*CNT_W-1:0]  count_nxt;
  logic [NUM_CH-1:0]        flag_nxt;
  logic [NUM_CH-1:0]        pulse_nxt;
  logic [CNT_W-1:0]         cur;
  logic [CNT_W-1:0]         inc;
  logic [CNT_W-1:0]         nxt;
  logic                     reload_evt;
  logic                     nflag;
  logic                     win_hit;
  logic [ID_W-1:0]          win_idx;

  // Reserved mode code falls back to wrap.
  assign mode_eff = (mode == MODE_RSVD) ? MODE_WRAP : mode_e'(mode);
  assign any_flag = |flag;

  always_comb begin
    count_nxt  = count;
    flag_nxt   = '0;
    pulse_nxt  = '0;
    cur        = '0;
    inc        = '0;
    nxt        = '0;
    reload_evt = 1'b0;
    nflag      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur        = count[i*CNT_W +: CNT_W];
      inc        = cur + CNT_W'(1);
      reload_evt = trigger[i] && (mode_eff == MODE_RELOAD) &&
                   ((inc == threshold) || (threshold == '0));

      if (clr[i]) begin
        nxt = '0;
      end else if (!trigger[i]) begin
        nxt = cur;
      end else begin
        case (mode_eff)
          MODE_SAT:    nxt = (cur >= threshold) ? cur : inc;
          MODE_RELOAD: nxt = reload_evt ? '0 : inc;
          default:     nxt = inc;
        endcase
      end

      // Flags are re-evaluated every cycle so threshold/mode changes take effect without a trigger.
      case (mode_eff)
        MODE_SAT:    nflag = (nxt >= threshold);
        MODE_RELOAD: nflag = reload_evt;
        default:     nflag = (nxt == threshold);
      endcase

      count_nxt[i*CNT_W +: CNT_W] = nxt;
      if (!clr[i]) begin
        flag_nxt[i]  = nflag;
        pulse_nxt[i] = (mode_eff == MODE_RELOAD) ? reload_evt : (nflag & ~flag[i]);
      end
    end
  end

  // Lowest-index pulse wins a tie.
  always_comb begin
    win_hit = |flag_pulse;
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (flag_pulse[i]) win_idx = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      flag         <= '0;
      flag_pulse   <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
    end else begin
      count      <= count_nxt;
      flag       <= flag_nxt;
      flag_pulse <= pulse_nxt;
      if (winner_clr) begin
        winner_valid <= 1'b0;
        winner_id    <= '0;
      end else if (!winner_valid && win_hit) begin
        winner_valid <= 1'b1;
        winner_id    <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_multi_flag_counter.sv
// Directed and randomized bench for multi_flag_counter against a behavioural channel/winner model.
module tb_multi_flag_counter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int ID_W   = 2;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       trigger;
  logic [NUM_CH-1:0]       clr;
  logic [CNT_W-1:0]        threshold;
  logic [1:0]              mode;
  logic                    winner_clr;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       flag;
  logic [NUM_CH-1:0]       flag_pulse;
  logic                    any_flag;
  logic                    winner_valid;
  logic [ID_W-1:0]         winner_id;

  int tests = 0;
  int fails = 0;

  int m_cnt   [NUM_CH];
  bit m_flag  [NUM_CH];
  bit m_pulse [NUM_CH];
  bit m_wv;
  int m_wid;

  multi_flag_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .clr          (clr),
    .threshold    (threshold),
    .mode         (mode),
    .winner_clr   (winner_clr),
    .count        (count),
    .flag         (flag),
    .flag_pulse   (flag_pulse),
    .any_flag     (any_flag),
    .winner_valid (winner_valid),
    .winner_id    (winner_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(count[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i]   = 0;
      m_flag[i]  = 1'b0;
      m_pulse[i] = 1'b0;
    end
    m_wv  = 1'b0;
    m_wid = 0;
  endtask

  // One clock edge of the reference: winner uses last cycle's pulses, channels use current inputs.
  task automatic model_step();
    int  md;
    int  thr;
    int  lim;
    bit  anyp;
    int  low;
    if (!rst) begin
      model_reset();
      return;
    end
    md   = (int'(mode) == 3) ? 0 : int'(mode);
    thr  = int'(threshold);
    lim  = 1 << CNT_W;
    anyp = 1'b0;
    low  = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m_pulse[i]) begin
        anyp = 1'b1;
        low  = i;
      end
    end
    if (winner_clr) begin
      m_wv  = 1'b0;
      m_wid = 0;
    end else if (!m_wv && anyp) begin
      m_wv  = 1'b1;
      m_wid = low;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      int n;
      bit ev;
      bit nf;
      c  = m_cnt[i];
      n  = c;
      ev = 1'b0;
      if (clr[i]) begin
        m_cnt[i]   = 0;
        m_flag[i]  = 1'b0;
        m_pulse[i] = 1'b0;
        continue;
      end
      if (trigger[i]) begin
        if (md == 0) begin
          n = (c + 1) % lim;
        end else if (md == 1) begin
          n = (c >= thr) ? c : c + 1;
        end else if (((c + 1) % lim == thr) || (thr == 0)) begin
          n  = 0;
          ev = 1'b1;
        end else begin
          n = (c + 1) % lim;
        end
      end
      if (md == 0)      nf = (n == thr);
      else if (md == 1) nf = (n >= thr);
      else              nf = ev;
      m_pulse[i] = (md == 2) ? ev : (nf && !m_flag[i]);
      m_flag[i]  = nf;
      m_cnt[i]   = n;
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH*CNT_W-1:0] ec;
    logic [NUM_CH-1:0]       ef;
    logic [NUM_CH-1:0]       ep;
    for (int i = 0; i < NUM_CH; i++) begin
      ec[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
      ef[i] = m_flag[i];
      ep[i] = m_pulse[i];
    end
    chk("model_count", 32'(count), 32'(ec));
    chk("model_flag", 32'(flag), 32'(ef));
    chk("model_flag_pulse", 32'(flag_pulse), 32'(ep));
    chk("model_any_flag", 32'(any_flag), 32'(|ef));
    chk("model_winner_valid", 32'(winner_valid), 32'(m_wv));
    chk("model_winner_id", 32'(winner_id), 32'(m_wid[ID_W-1:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int npulse;
    rst        = 1'b0;
    trigger    = '0;
    clr        = '0;
    threshold  = 4'd15;
    mode       = 2'd0;
    winner_clr = 1'b0;
    model_reset();

    // Reset and idle
    repeat (3) tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_winner_valid", 32'(winner_valid), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_flag", 32'(flag), 32'd0);
      chk("idle_pulse", 32'(flag_pulse), 32'd0);
      chk("idle_winner_valid", 32'(winner_valid), 32'd0);
    end

    // Wrap count on channel 0
    trigger = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 14) chk("wrap_pulse_early", 32'(flag_pulse[0]), 32'd0);
      if (k == 15) begin
        chk("wrap_count15", 32'(cnt_of(0)), 32'd15);
        chk("wrap_flag15", 32'(flag[0]), 32'd1);
        chk("wrap_pulse15", 32'(flag_pulse[0]), 32'd1);
      end
      if (k == 16) begin
        chk("wrap_count_roll", 32'(cnt_of(0)), 32'd0);
        chk("wrap_flag_roll", 32'(flag[0]), 32'd0);
        chk("wrap_winner_valid", 32'(winner_valid), 32'd1);
        chk("wrap_winner_id", 32'(winner_id), 32'd0);
      end
    end
    trigger = '0; clr = 4'hF; winner_clr = 1'b1;
    tick();
    clr = '0; winner_clr = 1'b0;

    // Saturate on channel 2, then clear beats trigger
    mode = 2'd1; threshold = 4'd5; trigger = 4'b0100;
    npulse = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      npulse += int'(flag_pulse[2]);
      if (k <= 5) chk("sat_count_ramp", 32'(cnt_of(2)), 32'(k));
    end
    chk("sat_count_hold", 32'(cnt_of(2)), 32'd5);
    chk("sat_flag_hold", 32'(flag[2]), 32'd1);
    chk("sat_single_pulse", 32'(npulse), 32'd1);
    clr = 4'b0100;
    tick();
    chk("clr_over_trig_count", 32'(cnt_of(2)), 32'd0);
    chk("clr_over_trig_flag", 32'(flag[2]), 32'd0);
    clr = '0; trigger = '0;

    // Reload on channel 1
    mode = 2'd2; threshold = 4'd3; trigger = 4'b0010;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("reload_count", 32'(cnt_of(1)), 32'(k % 3));
      chk("reload_flag", 32'(flag[1]), 32'((k % 3) == 0));
      chk("reload_pulse", 32'(flag_pulse[1]), 32'((k % 3) == 0));
    end
    trigger = '0;

    // Winner tie, late pulse, clear against a pending pulse
    mode = 2'd0; threshold = 4'd2; clr = 4'hF; winner_clr = 1'b1;
    tick();
    clr = '0; winner_clr = 1'b0;
    trigger = 4'b1010;
    repeat (2) tick();
    chk("tie_pulses", 32'(flag_pulse), 32'b1010);
    trigger = '0;
    tick();
    chk("tie_winner_valid", 32'(winner_valid), 32'd1);
    chk("tie_winner_id", 32'(winner_id), 32'd1);
    trigger = 4'b0100;
    repeat (2) tick();
    chk("late_pulse_ch2", 32'(flag_pulse[2]), 32'd1);
    trigger = '0;
    tick();
    chk("late_winner_id", 32'(winner_id), 32'd1);
    winner_clr = 1'b1;
    tick();
    winner_clr = 1'b0;
    chk("wclr_valid", 32'(winner_valid), 32'd0);
    trigger = 4'b0001;
    repeat (2) tick();
    chk("pend_pulse_ch0", 32'(flag_pulse[0]), 32'd1);
    trigger = '0; winner_clr = 1'b1;
    tick();
    chk("wclr_beats_latch", 32'(winner_valid), 32'd0);
    winner_clr = 1'b0;
    tick();
    chk("wclr_no_late_latch", 32'(winner_valid), 32'd0);

    // Runtime threshold drop in saturate, then async reset
    mode = 2'd1; threshold = 4'd15; clr = 4'hF; winner_clr = 1'b1;
    tick();
    clr = '0; winner_clr = 1'b0;
    trigger = 4'b1000;
    repeat (7) tick();
    trigger = '0;
    chk("thr_pre_count", 32'(cnt_of(3)), 32'd7);
    chk("thr_pre_flag", 32'(flag[3]), 32'd0);
    threshold = 4'd4;
    tick();
    chk("thr_drop_flag", 32'(flag[3]), 32'd1);
    chk("thr_drop_count", 32'(cnt_of(3)), 32'd7);
    chk("thr_drop_pulse", 32'(flag_pulse[3]), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_flag", 32'(flag), 32'd0);
    chk("async_rst_pulse", 32'(flag_pulse), 32'd0);
    chk("async_rst_any", 32'(any_flag), 32'd0);
    chk("async_rst_wv", 32'(winner_valid), 32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      if ((it % 25) == 0) begin
        threshold = CNT_W'($urandom);
        mode      = 2'($urandom);
      end
      trigger    = 4'($urandom);
      clr        = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      winner_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
